// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle MIPS control FSM and its datapath.
// The controller is the master: it reads op/flags and drives enables and selects.
interface mc_control_fsm_if #(
   parameter int OPW = 6,
   parameter int STW = 4
) ();
   logic [OPW-1:0] op;
   logic           zero;
   logic           mem_ready;

   logic           pcen;
   logic           pcwrite;
   logic           branch;
   logic           irwrite;
   logic           memwrite;
   logic           regwrite;
   logic           iord;
   logic           regdst;
   logic           memtoreg;
   logic           alusrca;
   logic [1:0]     alusrcb;
   logic [1:0]     pcsrc;
   logic [1:0]     aluop;
   logic [STW-1:0] state;
   logic           illegal_op;

   modport master (
      input  op, zero, mem_ready,
      output pcen, pcwrite, branch, irwrite, memwrite, regwrite, iord, regdst,
             memtoreg, alusrca, alusrcb, pcsrc, aluop, state, illegal_op
   );

   modport slave (
      output op, zero, mem_ready,
      input  pcen, pcwrite, branch, irwrite, memwrite, regwrite, iord, regdst,
             memtoreg, alusrca, alusrcb, pcsrc, aluop, state, illegal_op
   );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/mem/wb
// and decoding the datapath enables and mux selects from the current state.
module mc_control_fsm #(
   parameter int OPW = 6,
   parameter int STW = 4
) (
   input  logic               clk,
   input  logic               reset,
   mc_control_fsm_if.master   bus
);

   typedef enum logic [STW-1:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_e;

   localparam logic [OPW-1:0] OP_LW    = 6'b100011;
   localparam logic [OPW-1:0] OP_SW    = 6'b101011;
   localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPW-1:0] OP_J     = 6'b000010;

   state_e state_q, state_d;
   logic   illegal_op_q, illegal_op_d;
   state_e dec_state;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
   end

   // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d      = state_q;
      illegal_op_d = illegal_op_q;
      case (state_q)
         FETCH:   if (bus.mem_ready) state_d = DECODE;
         DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JEX;
               default: begin
                  state_d      = FETCH;
                  illegal_op_d = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            if (bus.op == OP_LW)      state_d = MEMRD;
            else if (bus.op == OP_SW) state_d = MEMWR;
            else                      state_d = FETCH;
         end
         MEMRD:   if (bus.mem_ready) state_d = MEMWB;
         MEMWR:   if (bus.mem_ready) state_d = FETCH;
         RTYPEEX: state_d = RTYPEWB;
         ADDIEX:  state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
      // Synchronous reset overrides any transition, including memory waits.
      if (reset) begin
         state_d      = FETCH;
         illegal_op_d = 1'b0;
      end
   end

   // Under reset the selects show FETCH values while the enables are gated off below.
   assign dec_state = reset ? FETCH : state_q;

   always_comb begin
      bus.pcwrite  = 1'b0;
      bus.branch   = 1'b0;
      bus.irwrite  = 1'b0;
      bus.memwrite = 1'b0;
      bus.regwrite = 1'b0;
      bus.iord     = 1'b0;
      bus.regdst   = 1'b0;
      bus.memtoreg = 1'b0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = 2'b00;
      bus.pcsrc    = 2'b00;
      bus.aluop    = 2'b00;
      case (dec_state)
         FETCH: begin
            bus.alusrcb = 2'b01;
            bus.irwrite = bus.mem_ready;
            bus.pcwrite = bus.mem_ready;
         end
         DECODE:  bus.alusrcb = 2'b11;
         MEMADR, ADDIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
         end
         MEMRD:   bus.iord = 1'b1;
         MEMWB: begin
            bus.memtoreg = 1'b1;
            bus.regwrite = 1'b1;
         end
         MEMWR: begin
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
         end
         RTYPEEX: begin
            bus.alusrca = 1'b1;
            bus.aluop   = 2'b10;
         end
         RTYPEWB: begin
            bus.regdst   = 1'b1;
            bus.regwrite = 1'b1;
         end
         BEQEX: begin
            bus.alusrca = 1'b1;
            bus.aluop   = 2'b01;
            bus.pcsrc   = 2'b01;
            bus.branch  = 1'b1;
         end
         ADDIWB:  bus.regwrite = 1'b1;
         JEX: begin
            bus.pcsrc   = 2'b10;
            bus.pcwrite = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         bus.irwrite  = 1'b0;
         bus.pcwrite  = 1'b0;
         bus.memwrite = 1'b0;
         bus.regwrite = 1'b0;
      end
      bus.pcen = bus.pcwrite | (bus.branch & bus.zero);
   end

   assign bus.state      = state_q;
   assign bus.illegal_op = illegal_op_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class through its
// state sequence and checks enables/selects against hand-derived values.
module tb_mc_control_fsm;

   localparam logic [5:0] LW    = 6'b100011;
   localparam logic [5:0] SW    = 6'b101011;
   localparam logic [5:0] RTYPE = 6'b000000;
   localparam logic [5:0] BEQ   = 6'b000100;
   localparam logic [5:0] ADDI  = 6'b001000;
   localparam logic [5:0] J     = 6'b000010;
   localparam logic [5:0] BAD   = 6'b111111;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   mc_control_fsm_if #(.OPW(6), .STW(4)) bif ();

   mc_control_fsm #(.OPW(6), .STW(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance one clock and sample 1ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bif.mem_ready = 1'b1;
      bif.op = LW;
      bif.zero = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         tests++;
         if ({bif.state, bif.pcen, bif.pcwrite, bif.irwrite, bif.memwrite, bif.regwrite, bif.illegal_op} !== {4'd0, 6'b0}) begin
            $display("FAIL reset_hold[%0d]: got state=%0d pcen=%b pcwr=%b irwr=%b memwr=%b regwr=%b ill=%b, want state=0 all 0",
                     i, bif.state, bif.pcen, bif.pcwrite, bif.irwrite, bif.memwrite, bif.regwrite, bif.illegal_op);
            fails++;
         end
         tests++;
         if ({bif.alusrcb, bif.iord, bif.alusrca} !== {2'b01, 1'b0, 1'b0}) begin
            $display("FAIL reset_selects[%0d]: got alusrcb=%b iord=%b alusrca=%b, want 01 0 0",
                     i, bif.alusrcb, bif.iord, bif.alusrca);
            fails++;
         end
      end
      reset = 1'b0;
      #1;
      tests++;
      if ({bif.state, bif.irwrite, bif.pcwrite, bif.pcen, bif.alusrcb} !== {4'd0, 3'b111, 2'b01}) begin
         $display("FAIL reset_release: got state=%0d irwr=%b pcwr=%b pcen=%b alusrcb=%b, want 0 1 1 1 01",
                  bif.state, bif.irwrite, bif.pcwrite, bif.pcen, bif.alusrcb);
         fails++;
      end
   endtask

   task automatic test_lw();
      logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      bif.op = LW;
      bif.mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) cyc();
         tests++;
         if ({bif.state, bif.regwrite, bif.memtoreg, bif.iord} !==
             {exp_st[i], exp_st[i] == 4'd4, exp_st[i] == 4'd4, exp_st[i] == 4'd3}) begin
            $display("FAIL lw_step[%0d]: got state=%0d regwr=%b memtoreg=%b iord=%b, want state=%0d",
                     i, bif.state, bif.regwrite, bif.memtoreg, bif.iord, exp_st[i]);
            fails++;
         end
      end
   endtask

   task automatic test_sw_wait();
      logic [3:0] exp_st [3] = '{4'd0, 4'd1, 4'd2};
      bif.op = SW;
      bif.mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) cyc();
         tests++;
         if ({bif.state, bif.regwrite, bif.memwrite} !== {exp_st[i], 2'b00}) begin
            $display("FAIL sw_pre[%0d]: got state=%0d regwr=%b memwr=%b, want state=%0d 0 0",
                     i, bif.state, bif.regwrite, bif.memwrite, exp_st[i]);
            fails++;
         end
      end
      cyc();
      for (int c = 0; c < 4; c++) begin
         bif.mem_ready = (c == 3);
         #1;
         tests++;
         if ({bif.state, bif.memwrite, bif.iord, bif.regwrite, bif.pcen} !== {4'd5, 4'b1100}) begin
            $display("FAIL sw_memwr[%0d]: got state=%0d memwr=%b iord=%b regwr=%b pcen=%b, want 5 1 1 0 0",
                     c, bif.state, bif.memwrite, bif.iord, bif.regwrite, bif.pcen);
            fails++;
         end
         cyc();
      end
      tests++;
      if ({bif.state, bif.memwrite, bif.regwrite} !== {4'd0, 2'b00}) begin
         $display("FAIL sw_done: got state=%0d memwr=%b regwr=%b, want 0 0 0",
                  bif.state, bif.memwrite, bif.regwrite);
         fails++;
      end
   endtask

   task automatic test_beq();
      bif.op = BEQ;
      bif.mem_ready = 1'b1;
      for (int z = 1; z >= 0; z--) begin
         bif.zero = logic'(z);
         cyc();
         cyc();
         tests++;
         if ({bif.state, bif.branch, bif.pcsrc, bif.aluop, bif.alusrca, bif.pcen, bif.pcwrite} !==
             {4'd8, 1'b1, 2'b01, 2'b01, 1'b1, logic'(z), 1'b0}) begin
            $display("FAIL beq_ex[z=%0d]: got state=%0d br=%b pcsrc=%b aluop=%b srca=%b pcen=%b pcwr=%b, want 8 1 01 01 1 %0d 0",
                     z, bif.state, bif.branch, bif.pcsrc, bif.aluop, bif.alusrca, bif.pcen, bif.pcwrite, z);
            fails++;
         end
         cyc();
         tests++;
         if (bif.state !== 4'd0) begin
            $display("FAIL beq_next[z=%0d]: got state=%0d, want 0", z, bif.state);
            fails++;
         end
      end
      // pcen must track zero within the BEQEX cycle itself.
      cyc();
      cyc();
      bif.zero = 1'b1;
      #1;
      tests++;
      if ({bif.state, bif.pcen} !== {4'd8, 1'b1}) begin
         $display("FAIL beq_zero_same_cycle: got state=%0d pcen=%b, want 8 1", bif.state, bif.pcen);
         fails++;
      end
      cyc();
      bif.zero = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd7};
      bif.op = RTYPE;
      bif.mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) cyc();
         tests++;
         if ({bif.state, bif.regdst, bif.regwrite, bif.aluop} !==
             {exp_st[i], exp_st[i] == 4'd7, exp_st[i] == 4'd7, (exp_st[i] == 4'd6) ? 2'b10 : 2'b00}) begin
            $display("FAIL rtype_step[%0d]: got state=%0d regdst=%b regwr=%b aluop=%b, want state=%0d",
                     i, bif.state, bif.regdst, bif.regwrite, bif.aluop, exp_st[i]);
            fails++;
         end
      end
      bif.op = J;
      cyc();
      tests++;
      if (bif.state !== 4'd0) begin
         $display("FAIL j_fetch: got state=%0d, want 0", bif.state);
         fails++;
      end
      cyc();
      cyc();
      tests++;
      if ({bif.state, bif.pcwrite, bif.pcsrc, bif.pcen, bif.regwrite} !== {4'd11, 1'b1, 2'b10, 1'b1, 1'b0}) begin
         $display("FAIL j_ex: got state=%0d pcwr=%b pcsrc=%b pcen=%b regwr=%b, want 11 1 10 1 0",
                  bif.state, bif.pcwrite, bif.pcsrc, bif.pcen, bif.regwrite);
         fails++;
      end
      cyc();
      tests++;
      if (bif.state !== 4'd0) begin
         $display("FAIL j_done: got state=%0d, want 0", bif.state);
         fails++;
      end
   endtask

   task automatic test_illegal_and_reset();
      bif.op = BAD;
      bif.mem_ready = 1'b1;
      cyc();
      tests++;
      if ({bif.state, bif.illegal_op} !== {4'd1, 1'b0}) begin
         $display("FAIL illegal_decode: got state=%0d ill=%b, want 1 0", bif.state, bif.illegal_op);
         fails++;
      end
      cyc();
      tests++;
      if ({bif.state, bif.illegal_op} !== {4'd0, 1'b1}) begin
         $display("FAIL illegal_set: got state=%0d ill=%b, want 0 1", bif.state, bif.illegal_op);
         fails++;
      end
      // ADDI afterwards: flag must stay sticky, 4-cycle sequence 0,1,9,10.
      bif.op = ADDI;
      cyc();
      cyc();
      tests++;
      if ({bif.state, bif.alusrca, bif.alusrcb, bif.illegal_op} !== {4'd9, 1'b1, 2'b10, 1'b1}) begin
         $display("FAIL addi_ex: got state=%0d srca=%b srcb=%b ill=%b, want 9 1 10 1",
                  bif.state, bif.alusrca, bif.alusrcb, bif.illegal_op);
         fails++;
      end
      cyc();
      tests++;
      if ({bif.state, bif.regwrite, bif.regdst, bif.memtoreg} !== {4'd10, 3'b100}) begin
         $display("FAIL addi_wb: got state=%0d regwr=%b regdst=%b memtoreg=%b, want 10 1 0 0",
                  bif.state, bif.regwrite, bif.regdst, bif.memtoreg);
         fails++;
      end
      // FETCH holds while memory is not ready, with enables low.
      bif.mem_ready = 1'b0;
      cyc();
      cyc();
      tests++;
      if ({bif.state, bif.irwrite, bif.pcwrite, bif.pcen, bif.illegal_op} !== {4'd0, 3'b000, 1'b1}) begin
         $display("FAIL fetch_wait: got state=%0d irwr=%b pcwr=%b pcen=%b ill=%b, want 0 0 0 0 1",
                  bif.state, bif.irwrite, bif.pcwrite, bif.pcen, bif.illegal_op);
         fails++;
      end
      // LW into MEMRD with memory stalled, then reset mid-wait.
      bif.mem_ready = 1'b1;
      bif.op = LW;
      cyc();
      cyc();
      bif.mem_ready = 1'b0;
      cyc();
      cyc();
      tests++;
      if ({bif.state, bif.iord, bif.illegal_op} !== {4'd3, 1'b1, 1'b1}) begin
         $display("FAIL memrd_hold: got state=%0d iord=%b ill=%b, want 3 1 1", bif.state, bif.iord, bif.illegal_op);
         fails++;
      end
      reset = 1'b1;
      #1;
      tests++;
      if ({bif.iord, bif.alusrcb, bif.regwrite, bif.pcen} !== {1'b0, 2'b01, 2'b00}) begin
         $display("FAIL reset_mid_memrd_outputs: got iord=%b srcb=%b regwr=%b pcen=%b, want 0 01 0 0",
                  bif.iord, bif.alusrcb, bif.regwrite, bif.pcen);
         fails++;
      end
      cyc();
      tests++;
      if ({bif.state, bif.illegal_op} !== {4'd0, 1'b0}) begin
         $display("FAIL reset_mid_memrd: got state=%0d ill=%b, want 0 0", bif.state, bif.illegal_op);
         fails++;
      end
      reset = 1'b0;
      bif.mem_ready = 1'b1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_lw();
      test_sw_wait();
      test_beq();
      test_back_to_back();
      test_illegal_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS main control unit. Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Generates the enables that drive the datapath state registers (PC, IR, register file write) and the memory write strobe, plus all mux selects and ALU op class.
- Sits directly upstream of the datapath flops: its pcen and irwrite outputs are the en inputs of the PC and IR registers.

Parameters:
- OPW, 6, opcode field width.
- STW, 4, state register width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- op  in  OPW  instruction opcode, from IR[31:26].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pcen  out  1  PC register enable: pcwrite | (branch & zero).
- pcwrite  out  1  unconditional PC write.
- branch  out  1  conditional branch cycle.
- irwrite  out  1  IR register enable.
- memwrite  out  1  memory write strobe.
- regwrite  out  1  register file write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- regdst  out  1  write register select: 0 = rt, 1 = rd.
- memtoreg  out  1  write data select: 0 = ALUOut, 1 = MDR.
- alusrca  out  1  ALU A select: 0 = PC, 1 = A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- aluop  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- state  out  STW  current state, for debug.
- illegal_op  out  1  sticky flag: an unsupported opcode was decoded.

Behaviour:
- Moore machine. All outputs are combinational decodes of state only, except pcen (uses zero) and the mem_ready-qualified enables in FETCH.
- Outputs not listed for a state are 0.
- Reset (synchronous):
  - state <= FETCH (0); illegal_op <= 0.
  - While reset is high, pcen, pcwrite, irwrite, memwrite and regwrite are forced to 0. Remaining outputs take their FETCH values.
  - Reset wins over every transition, including mid-instruction and mid-memory-wait.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 go to FETCH next cycle with all enables 0.
- Opcodes: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, ADDI=001000, J=000010.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite = pcwrite = mem_ready.
  - Holds in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target precompute). Next state by op:
  - LW/SW -> MEMADR; RTYPE -> RTYPEEX; BEQ -> BEQEX; ADDI -> ADDIEX; J -> JEX.
  - Any other op -> FETCH, and illegal_op is set (held until reset).
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD; SW -> MEMWR.
- MEMRD: iord=1. Holds until mem_ready, then -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1. memwrite stays high for every wait cycle. Holds until mem_ready, then -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH. pcen follows zero in the same cycle.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- JEX: pcsrc=10, pcwrite=1 -> FETCH.
- Latency with mem_ready tied high:
  - LW 5 cycles; SW, R-type, ADDI 4 cycles; BEQ, J 3 cycles.
  - Each memory wait cycle adds 1.
- pcen is asserted at most once per instruction outside FETCH; exactly once per instruction in FETCH.

Test Plan:
- Reset held 2 cycles with mem_ready=1 -> state=0, all enables 0 during reset. First cycle after release: irwrite=pcwrite=pcen=1, alusrcb=01.
- op=100011, mem_ready=1 -> states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4; iord=1 in state 3.
- op=101011, mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state=0. regwrite never asserted.
- op=000100: zero=1 -> in BEQEX pcen=1, pcsrc=01. Repeat with zero=0 -> pcen=0, next state 0.
- op=000000 then op=000010 back to back -> R-type states 0,1,6,7 with regdst=1 in state 7; J states 0,1,11 with pcwrite=1, pcsrc=10.
- op=111111 -> DECODE goes to FETCH, illegal_op=1 and stays 1 across the following instructions. Reset asserted mid-MEMRD -> state=0, illegal_op=0.
